instr_sequencer: RTL

//  Multi-cycle control sequencer for the SimpleMachine executor datapath.
//  - Accepts one 20-bit opcode per Start/Done handshake.
//  - Drives the shared Memory block's Select/Mode/address and the shared data bus through T-states.
//  - Holds the accumulator ACC. Replaces the ad-hoc T counter inside the executor.

---
 rtl/instr_sequencer_if.sv | 35 +++
 rtl/instr_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
// Handshake and memory-bus bundle between the SimpleMachine executor and its
// multi-cycle instruction sequencer.
interface instr_sequencer_if #(
   parameter int N = 8,
   parameter int M = 8
);
   logic          Start;
   logic [19:0]   OpCode;
   logic [M-1:0]  BusIn;
   logic [M-1:0]  BusOut;
   logic          BusOE;
   logic          MemSelect;
   logic          MemMode;
   logic [N-1:0]  MemAddr;
   logic [M-1:0]  Acc;
   logic          Carry;
   logic [2:0]    TState;
   logic          Busy;
   logic          Done;
   logic          Error;

   // Requester side (executor / bench): issues opcodes and models the memory.
   modport master (
      output Start, OpCode, BusIn,
      input  BusOut, BusOE, MemSelect, MemMode, MemAddr,
             Acc, Carry, TState, Busy, Done, Error
   );

   // Sequencer side.
   modport slave (
      input  Start, OpCode, BusIn,
      output BusOut, BusOE, MemSelect, MemMode, MemAddr,
             Acc, Carry, TState, Busy, Done, Error
   );
endinterface

// File: rtl/instr_sequencer.sv
// T-state sequencer: accepts one opcode per Start/Done handshake, walks the
// shared memory through read/write states and holds the accumulator.
module instr_sequencer #(
   parameter int N = 8,
   parameter int M = 8
) (
   input  logic               Clock,
   input  logic               ResetN,
   instr_sequencer_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_RD,
      S_RDCAP,
      S_WR,
      S_DONE
   } state_e;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_LDI   = 4'd1,
      OP_LOAD  = 4'd2,
      OP_STORE = 4'd3,
      OP_ADD   = 4'd4,
      OP_MOVE  = 4'd5
   } op_e;

   state_e        state_q, state_d;
   logic [19:0]   ir_q, ir_d;
   logic [M-1:0]  tmp_q, tmp_d;
   logic [M-1:0]  acc_q, acc_d;
   logic          carry_q, carry_d;
   logic [2:0]    tstate_q, tstate_d;

   op_e           op;
   logic          illegal;
   logic [N-1:0]  addr_a;
   logic [N-1:0]  addr_b;
   logic [M:0]    sum;

   logic          mem_select;
   logic          mem_mode;
   logic [N-1:0]  mem_addr;
   logic          bus_oe;
   logic [M-1:0]  bus_out;
   logic          done;
   logic          error;

   assign op      = op_e'(ir_q[19:16]);
   assign illegal = (ir_q[19:16] > 4'd5);
   assign addr_a  = ir_q[8 +: N];
   assign addr_b  = ir_q[0 +: N];
   assign sum     = {1'b0, acc_q} + {1'b0, bus.BusIn};

   // NOTE: every signal written here gets a default first, so no path through
   // the case statements can leave one unassigned and infer a latch.
   always_comb begin
      state_d    = state_q;
      ir_d       = ir_q;
      tmp_d      = tmp_q;
      acc_d      = acc_q;
      carry_d    = carry_q;
      mem_select = 1'b0;
      mem_mode   = 1'b0;
      mem_addr   = '0;
      bus_oe     = 1'b0;
      bus_out    = '0;
      done       = 1'b0;
      error      = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               ir_d    = bus.OpCode;
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            case (op)
               OP_LDI: begin
                  acc_d   = M'(ir_q[7:0]);
                  state_d = S_DONE;
               end
               OP_STORE:                  state_d = S_WR;
               OP_LOAD, OP_ADD, OP_MOVE:  state_d = S_RD;
               default:                   state_d = S_DONE;
            endcase
         end

         S_RD: begin
            mem_select = 1'b1;
            mem_addr   = addr_a;
            state_d    = S_RDCAP;
         end

         // Memory has had a full cycle to drive BusIn; capture at the closing edge.
         S_RDCAP: begin
            mem_select = 1'b1;
            mem_addr   = addr_a;
            case (op)
               OP_LOAD: begin
                  acc_d   = bus.BusIn;
                  state_d = S_DONE;
               end
               OP_ADD: begin
                  {carry_d, acc_d} = sum;
                  state_d          = S_DONE;
               end
               OP_MOVE: begin
                  tmp_d   = bus.BusIn;
                  state_d = S_WR;
               end
               default:   state_d = S_DONE;
            endcase
         end

         S_WR: begin
            mem_select = 1'b1;
            mem_mode   = 1'b1;
            bus_oe     = 1'b1;
            mem_addr   = (op == OP_MOVE) ? addr_b : addr_a;
            bus_out    = (op == OP_MOVE) ? tmp_q  : acc_q;
            state_d    = S_DONE;
         end

         S_DONE: begin
            done    = 1'b1;
            error   = illegal;
            state_d = S_IDLE;
         end

         default:   state_d = S_IDLE;
      endcase

      if (state_d == S_IDLE)     tstate_d = '0;
      else if (tstate_q == 3'd7) tstate_d = 3'd7;
      else                       tstate_d = tstate_q + 3'd1;
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge Clock or negedge ResetN) begin
      if (!ResetN) begin
         state_q  <= S_IDLE;
         ir_q     <= '0;
         tmp_q    <= '0;
         acc_q    <= '0;
         carry_q  <= 1'b0;
         tstate_q <= '0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         tmp_q    <= tmp_d;
         acc_q    <= acc_d;
         carry_q  <= carry_d;
         tstate_q <= tstate_d;
      end
   end

   // Bus controls decode straight from state, so an async reset drops them at once.
   assign bus.MemSelect = mem_select;
   assign bus.MemMode   = mem_mode;
   assign bus.MemAddr   = mem_addr;
   assign bus.BusOE     = bus_oe;
   assign bus.BusOut    = bus_out;
   assign bus.Done      = done;
   assign bus.Error     = error;
   assign bus.Busy      = (state_q != S_IDLE);
   assign bus.Acc       = acc_q;
   assign bus.Carry     = carry_q;
   assign bus.TState    = tstate_q;

endmodule
